regfile_mux: RTL and testbench
==============================

Name: regfile_mux

Overview:
- Parametrised register file with two independent read-select muxes and one write port.
- Successor to the fixed 8x16 read mux in BittyPro; it holds the register contents itself, so the datapath no longer wires eight discrete registers into a selector.
- Adds a per-register written/valid bitmap, synchronous clear, and an optional registered-read mode with write-first forwarding.
- Sits between the control unit (select/write strobes) and the ALU operand inputs.

Parameters:
- WIDTH, 16, bit width of each register and of the read/write data.
- NUM_REGS, 8, number of registers; legal range 2..32, power of two not required.
- SEL_W, $clog2(NUM_REGS), select width; derived, never overridden.
- REG_OUT, 1, 1 = registered read ports (1-cycle latency); 0 = combinational read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of all registers and valid bits.
- wr_en  in  1  write strobe.
- wr_sel  in  SEL_W  write register index.
- wr_data  in  WIDTH  write data.
- rd_sel_a  in  SEL_W  read port A index.
- rd_sel_b  in  SEL_W  read port B index.
- rd_a  out  WIDTH  read port A data.
- rd_b  out  WIDTH  read port B data.
- rd_a_vld  out  1  selected register A has been written since last reset/clear.
- rd_b_vld  out  1  same for port B.
- vld_map  out  NUM_REGS  valid bit per register, bit i = register i.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers 0 and vld_map 0.
  - REG_OUT=1: rd_a, rd_b, rd_a_vld, rd_b_vld = 0 immediately.
  - Takes effect mid-operation regardless of wr_en/clr; first edge after deassertion behaves normally.
- Write: at the rising edge with wr_en=1 and wr_sel<NUM_REGS, reg[wr_sel]<=wr_data and vld_map[wr_sel]<=1.
  - wr_sel>=NUM_REGS (only possible when NUM_REGS is not a power of two): write ignored, no state change.
- Clear: at the rising edge with clr=1, all registers<=0 and vld_map<=0.
  - clr has priority over a wr_en in the same cycle; that write is dropped.
- Read index out of range (>=NUM_REGS): data 0, vld 0.
- REG_OUT=0:
  - rd_a = reg[rd_sel_a] and rd_a_vld = vld_map[rd_sel_a], purely combinational; port B identical.
  - No forwarding: a write at edge N is visible on the read ports only after edge N.
- REG_OUT=1:
  - At each rising edge, rd_a<=the value reg[rd_sel_a] holds after that edge's update; rd_a_vld likewise.
  - Write-first forwarding: wr_en with wr_sel==rd_sel_a at the same edge returns wr_data with vld=1.
  - clr at the same edge returns 0 with vld=0 (clr beats forwarding).
  - Latency: select applied before edge N, data valid after edge N; ports update every cycle, no enable.
  - Port B identical and independent; both ports may select the same register.
- vld_map is always the registered state, in both REG_OUT modes.
- No X propagation: every output is defined for every input combination once reset has been applied.

Test Plan:
1. Reset then read all indices, REG_OUT=1 -> rd_a=rd_b=0, vld=0, vld_map=8'h00.
2. Write reg3=16'hBEEF; next cycle rd_sel_a=3, rd_sel_b=0 -> after the following edge rd_a=16'hBEEF, rd_a_vld=1, rd_b=0, rd_b_vld=0, vld_map=8'h08.
3. REG_OUT=1, same edge wr_en=1, wr_sel=5, wr_data=16'h1234 with rd_sel_a=5 -> rd_a=16'h1234, rd_a_vld=1 after that edge. REG_OUT=0 with the same stimulus -> rd_a=old value (0) before the edge, 16'h1234 after.
4. Fill all 8 registers with 16'h0100+i, assert clr together with wr_en to reg2=16'hFFFF -> all registers 0, vld_map=0, reg2 reads 0.
5. NUM_REGS=6 (SEL_W=3): write to wr_sel=7 with 16'hAAAA -> no state change; read rd_sel_a=6 -> rd_a=0, rd_a_vld=0.
6. Assert rst_n=0 mid-stream between edges after writes -> outputs and vld_map go to 0 without waiting for clk; a write on the first edge after release lands normally.

Source files
------------

// File: rtl/regfile_mux_if.sv
// Bus between the control unit and the register file: write strobe, read
// selects, read data with valid flags and the per-register valid bitmap.
interface regfile_mux_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8
);
  localparam int SEL_W = $clog2(NUM_REGS);

  logic                clr;
  logic                wr_en;
  logic [SEL_W-1:0]    wr_sel;
  logic [WIDTH-1:0]    wr_data;
  logic [SEL_W-1:0]    rd_sel_a;
  logic [SEL_W-1:0]    rd_sel_b;
  logic [WIDTH-1:0]    rd_a;
  logic [WIDTH-1:0]    rd_b;
  logic                rd_a_vld;
  logic                rd_b_vld;
  logic [NUM_REGS-1:0] vld_map;

  // Control unit side: drives strobes and selects, consumes operands.
  modport master (
    output clr, wr_en, wr_sel, wr_data, rd_sel_a, rd_sel_b,
    input  rd_a, rd_b, rd_a_vld, rd_b_vld, vld_map
  );

  // Register file side.
  modport slave (
    input  clr, wr_en, wr_sel, wr_data, rd_sel_a, rd_sel_b,
    output rd_a, rd_b, rd_a_vld, rd_b_vld, vld_map
  );
endinterface

// File: rtl/regfile_mux.sv
// Parametrised register file: one write port, two independent read muxes,
// a written/valid bit per register, synchronous clear, and an optional
// registered read stage that returns the post-edge contents (write-first).
module regfile_mux #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter bit REG_OUT  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mux_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_REGS);

  typedef logic [NUM_REGS-1:0][WIDTH-1:0] regs_t;

  regs_t               regs_q, regs_d;
  logic [NUM_REGS-1:0] vld_q,  vld_d;

  // Select one register and its valid bit; an index past the last register
  // matches nothing and so yields data 0 with valid 0.
  function automatic logic [WIDTH:0] read_sel(
    input regs_t               regs,
    input logic [NUM_REGS-1:0] vld,
    input logic [SEL_W-1:0]    sel
  );
    logic [WIDTH:0] res;
    res = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel == SEL_W'(i)) res = {vld[i], regs[i]};
    end
    return res;
  endfunction

  // Next state of the array: clear beats a write, and a write to a
  // non-existent index matches no register and is dropped.
  always_comb begin
    // NOTE: defaults assigned first so every path drives every bit; without
    // them a missed branch would infer a latch.
    regs_d = regs_q;
    vld_d  = vld_q;
    if (bus.clr) begin
      regs_d = '0;
      vld_d  = '0;
    end else if (bus.wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.wr_sel == SEL_W'(i)) begin
          regs_d[i] = bus.wr_data;
          vld_d[i]  = 1'b1;
        end
      end
    end
  end

  // Register array and valid bitmap.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the register contents are architecturally zero after reset, so
    // the storage itself carries the async reset rather than only vld_q.
    if (!rst_n) begin
      regs_q <= '0;
      vld_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      regs_q <= regs_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.vld_map = vld_q;

  generate
    if (REG_OUT) begin : g_reg_out
      logic [WIDTH:0] rd_a_q, rd_b_q;

      // Registered read: sample the post-update state, which gives
      // write-first forwarding and lets clear win over forwarding.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_a_q <= '0;
          rd_b_q <= '0;
        end else begin
          rd_a_q <= read_sel(regs_d, vld_d, bus.rd_sel_a);
          rd_b_q <= read_sel(regs_d, vld_d, bus.rd_sel_b);
        end
      end

      assign {bus.rd_a_vld, bus.rd_a} = rd_a_q;
      assign {bus.rd_b_vld, bus.rd_b} = rd_b_q;
    end else begin : g_comb_out
      // Combinational read of the stored state; a write shows up only after
      // its edge.
      assign {bus.rd_a_vld, bus.rd_a} = read_sel(regs_q, vld_q, bus.rd_sel_a);
      assign {bus.rd_b_vld, bus.rd_b} = read_sel(regs_q, vld_q, bus.rd_sel_b);
    end
  endgenerate
endmodule

// File: tb/tb_regfile_mux.sv
// Scoreboard bench for regfile_mux. Three instances share clock and reset:
// 8 regs registered (dut 0), 8 regs combinational (dut 1), 6 regs
// registered (dut 2). Stimulus pushes expected outputs tagged with the
// cycle they must appear in; a monitor compares them on the falling edge.
module tb_regfile_mux;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // Cycle counter seen by both stimulus and monitor.
  always @(posedge clk) cyc <= cyc + 1;

  regfile_mux_if #(.WIDTH(16), .NUM_REGS(8)) if_r ();
  regfile_mux_if #(.WIDTH(16), .NUM_REGS(8)) if_c ();
  regfile_mux_if #(.WIDTH(16), .NUM_REGS(6)) if_s ();

  regfile_mux #(.WIDTH(16), .NUM_REGS(8), .REG_OUT(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .bus(if_r)
  );
  regfile_mux #(.WIDTH(16), .NUM_REGS(8), .REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c)
  );
  regfile_mux #(.WIDTH(16), .NUM_REGS(6), .REG_OUT(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(if_s)
  );

  typedef struct {
    string       name;
    int          at;
    int          dut;
    logic [41:0] exp;   // {rd_a, rd_a_vld, rd_b, rd_b_vld, vld_map}
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {a,av,b,bv,map}=%h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] act_of(input int d);
    logic [41:0] res;
    res = '0;
    case (d)
      0:       res = {if_r.rd_a, if_r.rd_a_vld, if_r.rd_b, if_r.rd_b_vld, if_r.vld_map};
      1:       res = {if_c.rd_a, if_c.rd_a_vld, if_c.rd_b, if_c.rd_b_vld, if_c.vld_map};
      default: res = {if_s.rd_a, if_s.rd_a_vld, if_s.rd_b, if_s.rd_b_vld, 2'b00, if_s.vld_map};
    endcase
    return res;
  endfunction

  task automatic expect_out(input string name, input int at, input int d,
                            input logic [15:0] a, input logic av,
                            input logic [15:0] b, input logic bv,
                            input logic [7:0] map);
    exp_t e;
    e.name = $sformatf("%s/dut%0d/cyc%0d", name, d, at);
    e.at   = at;
    e.dut  = d;
    e.exp  = {a, av, b, bv, map};
    exp_q.push_back(e);
  endtask

  // Monitor: on every falling edge, compare all entries due this cycle.
  initial begin
    forever begin
      @(negedge clk);
      begin
        int i;
        i = 0;
        while (i < exp_q.size()) begin
          if (exp_q[i].at <= cyc) begin
            if (exp_q[i].at < cyc) begin
              n_tests++;
              n_fail++;
              $display("FAIL %s: sample slot missed (now cyc %0d)", exp_q[i].name, cyc);
            end else begin
              check(exp_q[i].name, act_of(exp_q[i].dut), exp_q[i].exp);
            end
            exp_q.delete(i);
          end else begin
            i++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic clr, input logic we, input logic [2:0] ws,
                       input logic [15:0] wd, input logic [2:0] sa, input logic [2:0] sb);
    if_r.clr = clr; if_r.wr_en = we; if_r.wr_sel = ws; if_r.wr_data = wd;
    if_r.rd_sel_a = sa; if_r.rd_sel_b = sb;
    if_c.clr = clr; if_c.wr_en = we; if_c.wr_sel = ws; if_c.wr_data = wd;
    if_c.rd_sel_a = sa; if_c.rd_sel_b = sb;
    if_s.clr = clr; if_s.wr_en = we; if_s.wr_sel = ws; if_s.wr_data = wd;
    if_s.rd_sel_a = sa; if_s.rd_sel_b = sb;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    step();
    for (int d = 0; d < 3; d++) expect_out("reset", cyc, d, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
    step();
    rst_n = 1'b1;

    // Every index reads zero / invalid after reset.
    for (int s = 0; s < 8; s++) begin
      drive(1'b0, 1'b0, 3'd0, 16'h0, 3'(s), 3'(7 - s));
      expect_out("empty_rd", cyc + 1, 0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
      expect_out("empty_rd", cyc,     1, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
      step();
    end

    // Write reg3, then read it on A with B on an unwritten register.
    drive(1'b0, 1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd0);
    expect_out("wr3",     cyc + 1, 0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h08);
    expect_out("wr3_pre", cyc,     1, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
    expect_out("wr3",     cyc + 1, 2, 16'h0, 1'b0, 16'h0, 1'b0, 8'h08);
    step();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd0);
    expect_out("rd3", cyc + 1, 0, 16'hBEEF, 1'b1, 16'h0, 1'b0, 8'h08);
    expect_out("rd3", cyc,     1, 16'hBEEF, 1'b1, 16'h0, 1'b0, 8'h08);
    step();

    // Same-edge write and read: forwarded when registered, old value when not.
    drive(1'b0, 1'b1, 3'd5, 16'h1234, 3'd5, 3'd3);
    expect_out("fwd5",     cyc + 1, 0, 16'h1234, 1'b1, 16'hBEEF, 1'b1, 8'h28);
    expect_out("nofwd5",   cyc,     1, 16'h0,    1'b0, 16'hBEEF, 1'b1, 8'h08);
    expect_out("fwd5",     cyc + 1, 2, 16'h1234, 1'b1, 16'hBEEF, 1'b1, 8'h28);
    step();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd3);
    expect_out("after5",   cyc,     1, 16'h1234, 1'b1, 16'hBEEF, 1'b1, 8'h28);
    step();
    // A write elsewhere must not be forwarded.
    drive(1'b0, 1'b1, 3'd1, 16'h1111, 3'd5, 3'd6);
    expect_out("no_xfwd",  cyc + 1, 0, 16'h1234, 1'b1, 16'h0, 1'b0, 8'h2A);
    step();
    // Both ports on the register being written; reg6 does not exist in dut2.
    drive(1'b0, 1'b1, 3'd6, 16'h6666, 3'd6, 3'd6);
    expect_out("fwd_ab",   cyc + 1, 0, 16'h6666, 1'b1, 16'h6666, 1'b1, 8'h6A);
    expect_out("pre_ab",   cyc,     1, 16'h0,    1'b0, 16'h0,    1'b0, 8'h2A);
    expect_out("oob_wr6",  cyc + 1, 2, 16'h0,    1'b0, 16'h0,    1'b0, 8'h2A);
    step();

    // Fill all registers, read them back on both ports.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 3'(i), 16'h0100 + 16'(i), 3'd0, 3'd0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i));
      expect_out("fill_rd", cyc + 1, 0, 16'h0100 + 16'(i), 1'b1, 16'h0100 + 16'(7 - i), 1'b1, 8'hFF);
      expect_out("fill_rd", cyc,     1, 16'h0100 + 16'(i), 1'b1, 16'h0100 + 16'(7 - i), 1'b1, 8'hFF);
      expect_out("fill_rd", cyc + 1, 2,
                 (i < 6) ? 16'h0100 + 16'(i) : 16'h0, i < 6,
                 (7 - i < 6) ? 16'h0100 + 16'(7 - i) : 16'h0, 7 - i < 6, 8'h3F);
      step();
    end

    // Clear together with a write: clear wins, including over forwarding.
    drive(1'b1, 1'b1, 3'd2, 16'hFFFF, 3'd2, 3'd7);
    expect_out("clr",     cyc + 1, 0, 16'h0,    1'b0, 16'h0,    1'b0, 8'h00);
    expect_out("clr_pre", cyc,     1, 16'h0102, 1'b1, 16'h0107, 1'b1, 8'hFF);
    expect_out("clr",     cyc + 1, 2, 16'h0,    1'b0, 16'h0,    1'b0, 8'h00);
    step();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd7);
    expect_out("clr_post", cyc + 1, 0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
    expect_out("clr_post", cyc,     1, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
    step();

    // Six-register instance: out-of-range write and reads.
    drive(1'b0, 1'b1, 3'd5, 16'h5555, 3'd0, 3'd0);
    step();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd6, 3'd7);
    if_s.wr_en   = 1'b1;
    if_s.wr_sel  = 3'd7;
    if_s.wr_data = 16'hAAAA;
    expect_out("oob_wr7", cyc + 1, 2, 16'h0, 1'b0, 16'h0, 1'b0, 8'h20);
    expect_out("idle67",  cyc + 1, 0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h20);
    step();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd6);
    expect_out("oob_rd6", cyc + 1, 2, 16'h5555, 1'b1, 16'h0, 1'b0, 8'h20);
    step();

    // Asynchronous reset between edges, then a write right after release.
    drive(1'b0, 1'b1, 3'd3, 16'h3333, 3'd3, 3'd5);
    step();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd5);
    #2;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) expect_out("async_rst", cyc, d, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 3'd4, 16'h4444, 3'd4, 3'd4);
    step();
    for (int d = 0; d < 3; d++) expect_out("rst_hold", cyc, d, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 3'd4, 16'h4444, 3'd4, 3'd5);
    expect_out("post_rst", cyc + 1, 0, 16'h4444, 1'b1, 16'h0, 1'b0, 8'h10);
    expect_out("post_pre", cyc,     1, 16'h0,    1'b0, 16'h0, 1'b0, 8'h00);
    expect_out("post_rst", cyc + 1, 2, 16'h4444, 1'b1, 16'h0, 1'b0, 8'h10);
    step();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd4, 3'd5);
    expect_out("post_rd",  cyc,     1, 16'h4444, 1'b1, 16'h0, 1'b0, 8'h10);
    step();

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) step();
    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: expected output never sampled", exp_q[0].name);
      exp_q.delete(0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
